// File: rtl/string_edit_ctrl.sv
// Cursor line editor: insert/backspace at a cursor, stream buffer on commit.
// Define STRING_EDIT_NEWLINE_EN to append 8'h0A after every committed line.
module string_edit_ctrl #(
  parameter int DEPTH = 16,
  parameter int PW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          i_aclr,
  input  logic [7:0]    i_ascii,
  input  logic          i_ascii_en,
  input  logic          i_left_en,
  input  logic          i_right_en,
  input  logic          i_down_en,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_valid,
  input  logic          i_tx_ready,
  output logic          o_busy,
  output logic          o_overflow,
  output logic [PW-1:0] o_len,
  output logic [PW-1:0] o_cursor,
  output logic [7:0]    o_cur_char
);

`ifdef STRING_EDIT_NEWLINE_EN
  localparam bit NL_EN = 1'b1;
`else
  localparam bit NL_EN = 1'b0;
`endif

  localparam logic [PW-1:0] FULL = PW'(DEPTH);

  typedef enum logic {EDIT, SEND} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] len_q, len_d;
  logic [PW-1:0] cur_q, cur_d;
  logic [PW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;
  logic [7:0]    data_q, data_d;
  logic          ovf_q, ovf_d;
  logic [PW:0]   nxt;

  assign nxt = {1'b0, idx_q} + 1'b1;

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    len_d   = len_q;
    cur_d   = cur_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = 1'b0;
    unique case (state_q)
      EDIT: begin
        if (i_down_en) begin
          state_d = SEND;
          idx_d   = '0;
          if (len_q != '0) begin
            valid_d = 1'b1;
            data_d  = mem_q[0];
          end else if (NL_EN) begin
            valid_d = 1'b1;
            data_d  = 8'h0A;
          end
        end else if (i_ascii_en) begin
          if (i_ascii == 8'h08) begin
            if (cur_q != '0) begin
              for (int k = 0; k < DEPTH-1; k++)
                if (k >= int'(cur_q) - 1 && k < int'(len_q) - 1)
                  mem_d[k] = mem_q[k+1];
              for (int k = 0; k < DEPTH; k++)
                if (k == int'(len_q) - 1)
                  mem_d[k] = 8'h20;
              len_d = len_q - 1'b1;
              cur_d = cur_q - 1'b1;
            end
          end else if (len_q == FULL) begin
            ovf_d = 1'b1;
          end else begin
            for (int k = 1; k < DEPTH; k++)
              if (k > int'(cur_q) && k <= int'(len_q))
                mem_d[k] = mem_q[k-1];
            for (int k = 0; k < DEPTH; k++)
              if (k == int'(cur_q))
                mem_d[k] = i_ascii;
            len_d = len_q + 1'b1;
            cur_d = cur_q + 1'b1;
          end
        end else if (i_left_en) begin
          if (cur_q != '0) cur_d = cur_q - 1'b1;
        end else if (i_right_en) begin
          if (cur_q < len_q) cur_d = cur_q + 1'b1;
        end
      end
      SEND: begin
        // idx == len is the terminator slot when the newline is enabled
        if (!valid_q || i_tx_ready) begin
          if (valid_q && nxt < {1'b0, len_q}) begin
            idx_d = nxt[PW-1:0];
            for (int k = 0; k < DEPTH; k++)
              if (k == int'(nxt))
                data_d = mem_q[k];
          end else if (valid_q && NL_EN && idx_q < len_q) begin
            idx_d  = nxt[PW-1:0];
            data_d = 8'h0A;
          end else begin
            state_d = EDIT;
            valid_d = 1'b0;
            len_d   = '0;
            cur_d   = '0;
            idx_d   = '0;
            for (int k = 0; k < DEPTH; k++)
              mem_d[k] = 8'h20;
          end
        end
      end
      default: state_d = EDIT;
    endcase
  end

  always_ff @(posedge clk or posedge i_aclr) begin
    if (i_aclr) begin
      state_q <= EDIT;
      for (int k = 0; k < DEPTH; k++)
        mem_q[k] <= 8'h20;
      len_q   <= '0;
      cur_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      len_q   <= len_d;
      cur_q   <= cur_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    o_cur_char = 8'h20;
    for (int k = 0; k < DEPTH; k++)
      if (k == int'(cur_q) && cur_q < len_q)
        o_cur_char = mem_q[k];
  end

  assign o_tx_data  = data_q;
  assign o_tx_valid = valid_q;
  assign o_busy     = (state_q == SEND);
  assign o_overflow = ovf_q;
  assign o_len      = len_q;
  assign o_cursor   = cur_q;

endmodule

// File: tb/tb_string_edit_ctrl.sv
// Scoreboard bench for string_edit_ctrl: expected tx bytes queued at commit,
// popped by a monitor on each observed transfer.
module tb_string_edit_ctrl;

  localparam int DEPTH = 16;
  localparam int PW = $clog2(DEPTH+1);

`ifdef STRING_EDIT_NEWLINE_EN
  localparam bit NL = 1'b1;
`else
  localparam bit NL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          i_aclr = 1'b0;
  logic [7:0]    i_ascii = 8'h00;
  logic          i_ascii_en = 1'b0;
  logic          i_left_en = 1'b0;
  logic          i_right_en = 1'b0;
  logic          i_down_en = 1'b0;
  logic [7:0]    o_tx_data;
  logic          o_tx_valid;
  logic          i_tx_ready = 1'b1;
  logic          o_busy;
  logic          o_overflow;
  logic [PW-1:0] o_len;
  logic [PW-1:0] o_cursor;
  logic [7:0]    o_cur_char;

  int vecs = 0;
  int errs = 0;
  logic [7:0] exp_q[$];

  string_edit_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .i_aclr(i_aclr),
    .i_ascii(i_ascii), .i_ascii_en(i_ascii_en),
    .i_left_en(i_left_en), .i_right_en(i_right_en),
    .i_down_en(i_down_en),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
    .i_tx_ready(i_tx_ready), .o_busy(o_busy),
    .o_overflow(o_overflow), .o_len(o_len),
    .o_cursor(o_cursor), .o_cur_char(o_cur_char)
  );

  always #5 clk = ~clk;

  // transfer will happen at the coming rising edge
  always @(negedge clk) begin
    if (o_tx_valid && i_tx_ready && !i_aclr) begin
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL tx_extra: got %h, expected no byte", o_tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (o_tx_data !== e) begin
          errs++;
          $display("FAIL tx_byte: got %h, expected %h", o_tx_data, e);
        end
      end
    end
  end

  task automatic ev(input logic [7:0] a, input logic ae,
                    input logic l, input logic r, input logic d);
    i_ascii = a; i_ascii_en = ae;
    i_left_en = l; i_right_en = r; i_down_en = d;
    @(posedge clk); #1;
    i_ascii_en = 0; i_left_en = 0; i_right_en = 0; i_down_en = 0;
  endtask

  task automatic key(input logic [7:0] a);
    ev(a, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic drain();
    int n = 0;
    i_tx_ready = 1'b1;
    while (o_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    vecs++;
    if (n >= 100) begin
      errs++;
      $display("FAIL drain_timeout: busy=%b after %0d cycles, expected 0", o_busy, n);
    end
    chk("drain_q_empty", exp_q.size(), 0);
    chk("drain_len", int'(o_len), 0);
    chk("drain_cursor", int'(o_cursor), 0);
  endtask

  task automatic test_reset();
    i_aclr = 1'b1;
    #3;
    i_aclr = 1'b0;
    @(posedge clk); #1;
    chk("rst_len", int'(o_len), 0);
    chk("rst_cursor", int'(o_cursor), 0);
    chk("rst_cur_char", int'(o_cur_char), 8'h20);
    chk("rst_valid", int'(o_tx_valid), 0);
    chk("rst_data", int'(o_tx_data), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_ovf", int'(o_overflow), 0);
  endtask

  task automatic test_insert();
    logic [7:0] s [4] = '{8'h41, 8'h58, 8'h42, 8'h43};
    key(8'h41); key(8'h42); key(8'h43);
    ev(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    ev(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    key(8'h58);
    chk("ins_len", int'(o_len), 4);
    chk("ins_cursor", int'(o_cursor), 2);
    chk("ins_cur_char", int'(o_cur_char), 8'h42);
    for (int i = 0; i < 4; i++)
      chk("ins_buf", int'(dut.mem_q[i]), int'(s[i]));
  endtask

  task automatic test_backspace();
    key(8'h08);
    chk("bs1_len", int'(o_len), 3);
    chk("bs1_cursor", int'(o_cursor), 1);
    chk("bs1_b0", int'(dut.mem_q[0]), 8'h41);
    chk("bs1_b1", int'(dut.mem_q[1]), 8'h42);
    chk("bs1_b2", int'(dut.mem_q[2]), 8'h43);
    chk("bs1_b3", int'(dut.mem_q[3]), 8'h20);
    key(8'h08);
    chk("bs2_len", int'(o_len), 2);
    chk("bs2_cursor", int'(o_cursor), 0);
    chk("bs2_b0", int'(dut.mem_q[0]), 8'h42);
    chk("bs2_b2", int'(dut.mem_q[2]), 8'h20);
    chk("bs2_cur_char", int'(o_cur_char), 8'h42);
    key(8'h08);
    chk("bs3_len", int'(o_len), 2);
    chk("bs3_cursor", int'(o_cursor), 0);
    chk("bs3_b1", int'(dut.mem_q[1]), 8'h43);
    ev(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    ev(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    ev(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("right_clamp", int'(o_cursor), 2);
    chk("right_cur_char", int'(o_cur_char), 8'h20);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h43);
    if (NL) exp_q.push_back(8'h0A);
    ev(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) key(8'h61 + 8'(i));
    chk("ovf_len16", int'(o_len), 16);
    chk("ovf_pre", int'(o_overflow), 0);
    key(8'h5A);
    chk("ovf_pulse", int'(o_overflow), 1);
    chk("ovf_len", int'(o_len), 16);
    chk("ovf_cursor", int'(o_cursor), 16);
    chk("ovf_last", int'(dut.mem_q[15]), 8'h70);
    @(posedge clk); #1;
    chk("ovf_single", int'(o_overflow), 0);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'h61 + 8'(i));
    if (NL) exp_q.push_back(8'h0A);
    ev(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_commit_stall();
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    key(8'h48); key(8'h49);
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h49);
    if (NL) exp_q.push_back(8'h0A);
    i_tx_ready = 1'b0;
    ev(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("cm_busy", int'(o_busy), 1);
    chk("cm_valid", int'(o_tx_valid), 1);
    for (int c = 0; c < 4; c++) begin
      i_tx_ready = pat[c];
      if (c == 1) begin
        i_left_en = 1'b1; i_ascii_en = 1'b1; i_ascii = 8'h5A;
      end
      if (c >= 2) begin
        chk("cm_hold_valid", int'(o_tx_valid), 1);
        chk("cm_hold_data", int'(o_tx_data), 8'h49);
      end
      @(posedge clk); #1;
      i_left_en = 1'b0; i_ascii_en = 1'b0;
    end
    if (!NL) chk("cm_done_busy", int'(o_busy), 0);
    drain();
    chk("cm_end_valid", int'(o_tx_valid), 0);
  endtask

  task automatic test_priority();
    ev(8'h51, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("pri_len", int'(o_len), 1);
    chk("pri_cursor", int'(o_cursor), 1);
    chk("pri_b0", int'(dut.mem_q[0]), 8'h51);
    ev(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("pri_lr", int'(o_cursor), 0);
    chk("pri_cur_char", int'(o_cur_char), 8'h51);
    exp_q.push_back(8'h51);
    if (NL) exp_q.push_back(8'h0A);
    ev(8'h52, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("pri_down_len", int'(o_len), 1);
    drain();
  endtask

  task automatic test_empty_commit();
    if (NL) exp_q.push_back(8'h0A);
    ev(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("emp_busy", int'(o_busy), 1);
    chk("emp_valid", int'(o_tx_valid), int'(NL));
    drain();
    key(8'h41);
    chk("emp_after_len", int'(o_len), 1);
    key(8'h08);
    chk("emp_bs_len", int'(o_len), 0);
  endtask

  task automatic test_aclr_mid_send();
    key(8'h48); key(8'h49);
    i_tx_ready = 1'b0;
    ev(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("acl_valid_pre", int'(o_tx_valid), 1);
    chk("acl_data_pre", int'(o_tx_data), 8'h48);
    #2;
    i_aclr = 1'b1;
    #1;
    chk("acl_valid_async", int'(o_tx_valid), 0);
    chk("acl_busy_async", int'(o_busy), 0);
    @(posedge clk); #1;
    i_aclr = 1'b0;
    i_tx_ready = 1'b1;
    @(posedge clk); #1;
    chk("acl_len", int'(o_len), 0);
    chk("acl_cursor", int'(o_cursor), 0);
    chk("acl_cur_char", int'(o_cur_char), 8'h20);
    chk("acl_q_empty", exp_q.size(), 0);
  endtask

  initial begin
    test_reset();
    test_insert();
    test_backspace();
    test_overflow();
    test_commit_stall();
    test_priority();
    test_empty_commit();
    test_aclr_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/string_edit_ctrl.md
# string_edit_ctrl

Cursor-based line-editing controller for the string builder. Consumes the one-cycle key events produced by the key decoder (character, cursor left/right, commit), maintains an editable character buffer with insert and backspace at a cursor, and on commit streams the buffer out over a valid/ready byte port before clearing it. It sits between the key decoder and whatever consumes finished strings, such as a UART transmitter or a display RAM writer. It also exposes the character under the cursor for the hex displays.

## Interface
Parameters:
- `DEPTH`, default 16: buffer capacity in characters; legal values are DEPTH ≥ 2.
- `PW`, default $clog2(DEPTH+1): width of the cursor and length fields; derived, do not override.

Ports:
- `clk`, in, 1: sole clock; everything is on the rising edge.
- `i_aclr`, in, 1: reset, asynchronous and active-high.
- `i_ascii`, in, 8: character code, qualified by `i_ascii_en`. The code 8'h08 means backspace.
- `i_ascii_en`, in, 1: one-cycle character event.
- `i_left_en`, in, 1: one-cycle cursor-left event.
- `i_right_en`, in, 1: one-cycle cursor-right event.
- `i_down_en`, in, 1: one-cycle commit event.
- `o_tx_data`, out, 8: output byte.
- `o_tx_valid`, out, 1: `o_tx_data` is valid.
- `i_tx_ready`, in, 1: consumer accepts the byte; a transfer occurs when valid and ready are both high.
- `o_busy`, out, 1: high while in the SEND state.
- `o_overflow`, out, 1: one-cycle pulse when an insert is dropped because the buffer is full.
- `o_len`, out, PW: number of characters stored.
- `o_cursor`, out, PW: cursor position, in the range 0..o_len.
- `o_cur_char`, out, 8: buf[o_cursor] when o_cursor < o_len, otherwise 8'h20.

## Operation
- Storage is a DEPTH×8 register array buf[0..DEPTH-1]. Valid characters occupy indices 0..len-1.
- The state machine has two states, EDIT and SEND.
- In EDIT, at most one event is accepted per cycle. Priority is down > ascii > left > right; lower-priority events in the same cycle are discarded.
  - Insert (ascii_en with a code other than 8'h08), when len < DEPTH:
    - buf[k+1] ← buf[k] for cursor ≤ k < len.
    - buf[cursor] ← i_ascii.
    - len+1 and cursor+1.
  - Insert when len == DEPTH: the event is dropped and `o_overflow` pulses.
  - Backspace (8'h08), when cursor > 0:
    - buf[k-1] ← buf[k] for cursor ≤ k < len.
    - buf[len-1] ← 8'h20.
    - len−1 and cursor−1.
  - Backspace at cursor 0 is a no-op.
  - Left: cursor−1 if cursor > 0, else no-op. Right: cursor+1 if cursor < len, else no-op. There is no wrap-around.
  - Down: enter SEND with read index idx ← 0.
- In SEND, all key events are ignored and `o_busy` = 1.
  - `o_tx_data` = buf[idx] while idx < len.
  - On each transfer, idx+1.
  - After the final transfer: buf is filled with 8'h20, len ← 0, cursor ← 0, and the state returns to EDIT.
- Commit with len == 0 is governed by the configuration macro (see Configuration).
- Reset values:
  - State EDIT, len 0, cursor 0, buf all 8'h20.
  - `o_tx_valid` 0, `o_tx_data` 8'h00, `o_busy` 0, `o_overflow` 0.
  - `o_cur_char` therefore reads 8'h20.

## Timing
- All outputs are registered except `o_cur_char`, which is combinational from registers.
- The effect of an event (buf, len, cursor, `o_overflow`) is visible the cycle after the event.
- Down accepted at edge N: `o_busy` and `o_tx_valid` are high after edge N. The first byte is presented in the same cycle.
- `o_tx_valid` and `o_tx_data` hold stable until a transfer. With ready held high, the block sustains one byte per cycle.
- After the last transfer at edge M: `o_tx_valid` = 0, `o_busy` = 0, and EDIT is active after edge M. Events arriving at edge M+1 are accepted.
- Asserting `i_aclr` mid-send drops `o_tx_valid` immediately; the buffer content is lost.

## Configuration
- `STRING_EDIT_NEWLINE_EN`
  - Defined: after the last buffer byte, SEND emits one extra byte 8'h0A before returning to EDIT. A commit with len == 0 sends only 8'h0A.
  - Undefined: there is no terminator. A commit with len == 0 enters SEND and returns to EDIT on the next edge with `o_tx_valid` never asserted.

## Test plan
- Type 'A','B','C' (8'h41,8'h42,8'h43), then left ×2, then 'X':
  - Expect buf = "AXBC", len 4, cursor 2, `o_cur_char` 8'h42.
- From "AXBC" with cursor 2, send backspace (8'h08):
  - Expect "ABC", len 3, cursor 1.
  - Then backspace ×2: the first gives "BC", cursor 0; the second is a no-op.
- With DEPTH = 16, send 17 inserts:
  - Expect len 16, a single-cycle `o_overflow` on the 17th, and buf unchanged by it.
- Commit "HI" with `i_tx_ready` toggling 1,0,0,1:
  - Expect bytes 8'h48, then 8'h49 held through the stall, then 8'h0A if `STRING_EDIT_NEWLINE_EN` is defined.
  - Expect `o_busy` low and len 0 after the last transfer. Left and 'Z' events during SEND are ignored.
- In the same cycle, assert `i_ascii_en`('Q') and `i_left_en` with cursor 0 and len 0:
  - Expect 'Q' inserted and cursor 1; the left event is discarded.
- Assert `i_aclr` asynchronously mid-SEND:
  - Expect `o_tx_valid` 0 without waiting for a clock edge.
  - After release: len 0, cursor 0, `o_cur_char` 8'h20.
